vend_dispense_ctrl: RTL and testbench

VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

---
 rtl/vend_pkg.sv | 17 +
 rtl/vend_fifo.sv | 75 +++++++
 rtl/vend_dispense_ctrl.sv | 147 ++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and default parameters for the vend dispense controller.
package vend_pkg;

  localparam int CHANGE_W          = 2;
  localparam int FIFO_DEPTH_DEF    = 4;
  localparam int MOTOR_TIMEOUT_DEF = 16;
  localparam int GAP_CYCLES_DEF    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISPENSE,
    ST_CHANGE,
    ST_GAP,
    ST_FAULT
  } state_e;

endpackage

// File: rtl/vend_fifo.sv
// Synchronous FIFO holding the change count of each pending vend.
// DEPTH must be a power of two so the pointers wrap naturally.
module vend_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_en;
  logic             pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;
  assign rdata   = mem_q[rd_ptr_q];

  // Next pointer and occupancy; a flush empties the queue outright.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; entries are only ever read behind a valid count.
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: queues vends, runs the motor with a timeout,
// pays out change one coin per hopper ack, then settles before the next vend.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF,
  parameter int MOTOR_TIMEOUT = MOTOR_TIMEOUT_DEF,
  parameter int GAP_CYCLES    = GAP_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vend_valid,
  input  logic [CHANGE_W-1:0] vend_change,
  output logic                vend_ready,
  output logic                motor_on,
  input  logic                motor_done,
  output logic                hopper_pulse,
  input  logic                hopper_ack,
  input  logic                fault_clr,
  output logic                busy,
  output logic                fault,
  output logic                overflow
);

  localparam int TW = $clog2(MOTOR_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  // GAP lasts GAP_CYCLES cycles: the counter is loaded with one less and leaves at zero.
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [CHANGE_W-1:0] coin_cnt_q, coin_cnt_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  logic                hopper_pulse_q, hopper_pulse_d;
  logic                overflow_q, overflow_d;

  logic                fifo_push, fifo_pop, fifo_flush;
  logic                fifo_full, fifo_empty;
  logic [CHANGE_W-1:0] fifo_rdata;

  assign vend_ready   = !fifo_full && (state_q != ST_FAULT);
  assign fifo_push    = vend_valid && vend_ready;
  assign motor_on     = (state_q == ST_DISPENSE);
  assign hopper_pulse = hopper_pulse_q;
  assign fault        = (state_q == ST_FAULT);
  assign busy         = (state_q != ST_IDLE) || !fifo_empty;
  assign overflow     = overflow_q;

  vend_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CHANGE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (vend_change),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, counter and pulse logic for the dispense sequence.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    coin_cnt_d     = coin_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    hopper_pulse_d = 1'b0;
    fifo_pop       = 1'b0;
    fifo_flush     = 1'b0;
    overflow_d     = vend_valid && !vend_ready;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          coin_cnt_d = fifo_rdata;
          timer_d    = TW'(MOTOR_TIMEOUT);
          state_d    = ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        // motor_done takes priority over a timeout landing on the same cycle.
        if (motor_done) begin
          timer_d = '0;
          if (coin_cnt_q == '0) begin
            gap_cnt_d = GAP_LOAD;
            state_d   = ST_GAP;
          end else begin
            hopper_pulse_d = 1'b1;
            state_d        = ST_CHANGE;
          end
        end else if (timer_q <= TW'(1)) begin
          timer_d = '0;
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_CHANGE: begin
        // A new coin is only requested after the previous one is acknowledged.
        if (hopper_ack && (coin_cnt_q != '0)) begin
          coin_cnt_d = coin_cnt_q - CHANGE_W'(1);
          if (coin_cnt_q == CHANGE_W'(1)) begin
            gap_cnt_d = GAP_LOAD;
            state_d   = ST_GAP;
          end else begin
            hopper_pulse_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - GW'(1);
      end
      ST_FAULT: begin
        if (fault_clr) begin
          fifo_flush = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller registers; reset aborts any operation in progress on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      coin_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      hopper_pulse_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      coin_cnt_q     <= coin_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      hopper_pulse_q <= hopper_pulse_d;
      overflow_q     <= overflow_d;
    end
  end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl: a queue-based reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_vend_dispense_ctrl;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int GAP     = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       vend_valid;
  logic [1:0] vend_change;
  logic       vend_ready, motor_on, hopper_pulse, busy, fault, overflow;
  logic       fault_clr;
  logic       motor_done, hopper_ack;
  logic       auto_md = 1'b0, man_md = 1'b0;
  logic       auto_ack = 1'b0, man_ack = 1'b0;

  assign motor_done = auto_md | man_md;
  assign hopper_ack = auto_ack | man_ack;

  always #5 clk = ~clk;

  vend_dispense_ctrl #(
    .FIFO_DEPTH    (DEPTH),
    .MOTOR_TIMEOUT (TIMEOUT),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vend_valid   (vend_valid),
    .vend_change  (vend_change),
    .vend_ready   (vend_ready),
    .motor_on     (motor_on),
    .motor_done   (motor_done),
    .hopper_pulse (hopper_pulse),
    .hopper_ack   (hopper_ack),
    .fault_clr    (fault_clr),
    .busy         (busy),
    .fault        (fault),
    .overflow     (overflow)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Motor sensor: pulses motor_done in the motor_delay-th cycle of motor_on.
  int motor_delay = 5;
  bit motor_en    = 1'b1;
  int mcnt        = 0;
  always @(posedge clk) begin
    #1;
    auto_md = 1'b0;
    if (motor_on) begin
      mcnt++;
      if (motor_en && mcnt == motor_delay) auto_md = 1'b1;
    end else begin
      mcnt = 0;
    end
  end

  // Hopper sensor: acks hop_delay cycles after each observed pulse.
  int hop_delay = 2;
  bit hop_en    = 1'b1;
  int hpend     = 0;
  always @(posedge clk) begin
    #1;
    auto_ack = 1'b0;
    if (hpend > 0) begin
      hpend--;
      if (hpend == 0) auto_ack = 1'b1;
    end
    if (hop_en && hopper_pulse) hpend = hop_delay;
  end

  // Reference model: a queue of pending change counts and the current activity.
  localparam int M_IDLE = 0, M_DISP = 1, M_CHG = 2, M_GAP = 3, M_FAULT = 4;
  int m_mode  = M_IDLE;
  int m_q[$];
  int m_coins = 0;
  int m_run   = 0;
  int m_gap   = 0;
  bit m_pulse = 1'b0;
  bit m_ovf   = 1'b0;

  always @(posedge clk) begin : model_blk
    bit rdy;
    bit nxt_pulse;
    if (!rst) begin
      m_q.delete();
      m_mode  = M_IDLE;
      m_coins = 0;
      m_run   = 0;
      m_gap   = 0;
      m_pulse = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      rdy       = (m_q.size() < DEPTH) && (m_mode != M_FAULT);
      nxt_pulse = 1'b0;
      case (m_mode)
        M_IDLE: if (m_q.size() > 0) begin
          m_coins = m_q.pop_front();
          m_run   = 0;
          m_mode  = M_DISP;
        end
        M_DISP: begin
          m_run++;
          if (motor_done) begin
            if (m_coins == 0) begin m_mode = M_GAP; m_gap = GAP; end
            else begin m_mode = M_CHG; nxt_pulse = 1'b1; end
          end else if (m_run == TIMEOUT) begin
            m_mode = M_FAULT;
          end
        end
        M_CHG: if (hopper_ack) begin
          m_coins--;
          if (m_coins == 0) begin m_mode = M_GAP; m_gap = GAP; end
          else nxt_pulse = 1'b1;
        end
        M_GAP: begin
          m_gap--;
          if (m_gap == 0) m_mode = M_IDLE;
        end
        default: if (fault_clr) begin
          m_q.delete();
          m_mode = M_IDLE;
        end
      endcase
      if (vend_valid && rdy) m_q.push_back(int'(vend_change));
      m_ovf   = vend_valid && !rdy;
      m_pulse = nxt_pulse;
    end
  end

  // Per-cycle comparison against the model, plus event counters for the scenarios.
  int n_starts = 0, n_mcyc = 0, n_pulse = 0, n_ovf = 0, n_busy = 0, n_fault = 0;
  bit prev_motor = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("motor_on",     motor_on,     32'(m_mode == M_DISP));
      check("hopper_pulse", hopper_pulse, 32'(m_pulse));
      check("fault",        fault,        32'(m_mode == M_FAULT));
      check("busy",         busy,         32'((m_mode != M_IDLE) || (m_q.size() > 0)));
      check("vend_ready",   vend_ready,   32'((m_q.size() < DEPTH) && (m_mode != M_FAULT)));
      check("overflow",     overflow,     32'(m_ovf));
      if (motor_on === 1'b1 && !prev_motor) n_starts++;
      prev_motor = (motor_on === 1'b1);
      if (motor_on === 1'b1)     n_mcyc++;
      if (hopper_pulse === 1'b1) n_pulse++;
      if (overflow === 1'b1)     n_ovf++;
      if (busy === 1'b1)         n_busy++;
      if (fault === 1'b1)        n_fault++;
    end
  end

  task automatic wait_idle(input int budget);
    int k = 0;
    do begin
      step();
      k++;
    end while (busy !== 1'b0 && k < budget);
    check("wait_idle", busy, 0);
  endtask

  task automatic push_one(input logic [1:0] chg);
    vend_valid  = 1'b1;
    vend_change = chg;
    step();
    vend_valid  = 1'b0;
  endtask

  int s_mcyc, s_pulse, s_busy, s_starts, s_ovf, s_fault;
  task automatic snap();
    s_mcyc = n_mcyc; s_pulse = n_pulse; s_busy = n_busy;
    s_starts = n_starts; s_ovf = n_ovf; s_fault = n_fault;
  endtask

  int chg_tab[6] = '{0, 1, 0, 1, 0, 3};

  initial begin
    rst = 1'b0; vend_valid = 1'b0; vend_change = 2'd0; fault_clr = 1'b0;
    step();
    chk_en = 1'b1;
    check("rst_busy",  busy,         0);
    check("rst_ready", vend_ready,   1);
    check("rst_motor", motor_on,     0);
    check("rst_pulse", hopper_pulse, 0);
    check("rst_fault", fault,        0);
    check("rst_ovf",   overflow,     0);
    step();
    rst = 1'b1;
    step();

    // Single vend with two coins of change.
    snap();
    push_one(2'd2);
    wait_idle(100);
    check("t1_motor_cycles", n_mcyc - s_mcyc,   5);
    check("t1_pulses",       n_pulse - s_pulse, 2);
    check("t1_busy_cycles",  n_busy - s_busy,   15);

    // Zero change: straight from motor to settle.
    snap();
    push_one(2'd0);
    wait_idle(100);
    check("t2_motor_cycles", n_mcyc - s_mcyc,   5);
    check("t2_pulses",       n_pulse - s_pulse, 0);
    check("t2_busy_cycles",  n_busy - s_busy,   9);

    // Back-to-back: five accepted, the sixth dropped while full.
    snap();
    vend_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      vend_change = 2'(chg_tab[i]);
      step();
      if (i == 4) begin
        check("t3_full_ready", vend_ready, 0);
        check("t3_no_ovf_yet", n_ovf - s_ovf, 0);
      end
    end
    vend_valid = 1'b0;
    check("t3_ovf_pulse", overflow, 1);
    wait_idle(300);
    check("t3_starts", n_starts - s_starts, 5);
    check("t3_pulses", n_pulse - s_pulse,   2);
    check("t3_ovf",    n_ovf - s_ovf,       1);

    // motor_done on the last permitted cycle beats the timeout.
    snap();
    motor_delay = TIMEOUT;
    push_one(2'd0);
    wait_idle(100);
    check("t4_motor_cycles", n_mcyc - s_mcyc,   16);
    check("t4_no_fault",     n_fault - s_fault, 0);
    check("t4_busy_cycles",  n_busy - s_busy,   20);
    motor_delay = 5;

    // Timeout into FAULT with one vend still queued; fault_clr flushes it.
    snap();
    motor_en   = 1'b0;
    vend_valid = 1'b1; vend_change = 2'd1; step();
    vend_change = 2'd2; step();
    vend_valid = 1'b0;
    begin
      int k = 0;
      while (fault !== 1'b1 && k < 60) begin step(); k++; end
    end
    check("t5_fault",        fault,           1);
    check("t5_motor_cycles", n_mcyc - s_mcyc, 16);
    check("t5_ready",        vend_ready,      0);
    check("t5_motor_off",    motor_on,        0);
    check("t5_busy",         busy,            1);
    push_one(2'd3);
    check("t5_fault_ovf",    overflow,        1);
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    check("t5_cleared",      fault,           0);
    check("t5_flushed",      busy,            0);
    check("t5_ready_back",   vend_ready,      1);
    for (int i = 0; i < 5; i++) step();
    check("t5_starts",       n_starts - s_starts, 1);
    motor_en = 1'b1;

    // Reset during CHANGE aborts the payout; a late ack does nothing.
    snap();
    hop_en = 1'b0;
    push_one(2'd3);
    begin
      int k = 0;
      while (hopper_pulse !== 1'b1 && k < 40) begin step(); k++; end
    end
    check("t6_first_pulse", hopper_pulse, 1);
    rst = 1'b0;
    step();
    check("t6_rst_motor", motor_on,     0);
    check("t6_rst_pulse", hopper_pulse, 0);
    check("t6_rst_busy",  busy,         0);
    check("t6_rst_ready", vend_ready,   1);
    check("t6_rst_fault", fault,        0);
    rst = 1'b1;
    step();
    man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    step();
    step();
    check("t6_pulses", n_pulse - s_pulse, 1);
    check("t6_idle",   busy,              0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
